// File: rtl/vp_mac_job_sequencer.sv
// Job sequencer in front of the variable-precision temporal MAC: frames precision/scale/data beats,
// captures the single MAC result and forwards it. Optional cycle counter: VP_SEQ_PERF_CNT_EN.
module vp_mac_job_sequencer #(
   parameter int AXIS_DW  = 32,
   parameter int MAX_PREC = 8
) (
   input  logic               CLK,
   input  logic               RESETN,
   input  logic               CMD_VALID,
   output logic               CMD_READY,
   input  logic [3:0]         CMD_PRECISION,
   input  logic [31:0]        CMD_SCALE,
   input  logic [15:0]        CMD_LEN,
   input  logic [7:0]         CMD_TID,
   input  logic               SD_AXIS_TVALID,
   output logic               SD_AXIS_TREADY,
   input  logic [AXIS_DW-1:0] SD_AXIS_TDATA,
   output logic               M_MAC_TVALID,
   input  logic               M_MAC_TREADY,
   output logic [AXIS_DW-1:0] M_MAC_TDATA,
   output logic               M_MAC_TLAST,
   output logic               M_MAC_TUSER,
   output logic [7:0]         M_MAC_TID,
   input  logic               S_MAC_TVALID,
   output logic               S_MAC_TREADY,
   input  logic [AXIS_DW-1:0] S_MAC_TDATA,
   input  logic [7:0]         S_MAC_TID,
   output logic               MO_AXIS_TVALID,
   input  logic               MO_AXIS_TREADY,
   output logic [AXIS_DW-1:0] MO_AXIS_TDATA,
   output logic [7:0]         MO_AXIS_TID,
   output logic               MO_AXIS_TLAST,
   output logic               BUSY,
   output logic               JOB_DONE,
   output logic [1:0]         ERR_CODE,
   output logic [15:0]        JOB_CNT
`ifdef VP_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]        PERF_CYC
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_PREC,
      ST_SEND_SCALE,
      ST_STREAM,
      ST_WAIT_RES,
      ST_OUT_RES,
      ST_DONE
   } state_t;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_ZERO_LEN = 2'b01;
   localparam logic [1:0] ERR_BAD_PREC = 2'b10;
   localparam logic [1:0] ERR_TID      = 2'b11;

   state_t               r_state;
   state_t               w_state_next;
   logic [3:0]           r_prec;
   logic [31:0]          r_scale;
   logic [15:0]          r_len;
   logic [7:0]           r_tid;
   logic [15:0]          r_beat;
   logic [1:0]           r_err;
   logic [AXIS_DW-1:0]   r_res_data;
   logic [7:0]           r_res_tid;
   logic [15:0]          r_job_cnt;

   logic                 w_len_zero;
   logic                 w_prec_bad;
   logic                 w_last;
   logic                 w_mac_hs;
   logic [AXIS_DW-1:0]   w_prec_ext;
   logic [AXIS_DW-1:0]   w_scale_ext;
   logic [AXIS_DW-1:0]   w_sd_ext;
   logic                 w_mac_valid;
   logic [AXIS_DW-1:0]   w_mac_data;
   logic                 w_mac_last;
   logic                 w_mac_user;
   logic [7:0]           w_mac_tid;
   logic                 w_sd_ready;
   logic                 w_res_ready;
   logic                 w_unused_sd;

   // Only the activation/weight pair in the low half-word is forwarded.
   assign w_unused_sd = ^SD_AXIS_TDATA[AXIS_DW-1:16];

   assign w_len_zero = (CMD_LEN == 16'd0);
   assign w_prec_bad = ({28'd0, CMD_PRECISION} > 32'(MAX_PREC));
   assign w_last     = (r_beat == (r_len - 16'd1));
   assign w_mac_hs   = w_mac_valid && M_MAC_TREADY;

   always_comb begin
      w_prec_ext        = '0;
      w_prec_ext[3:0]   = r_prec;
      w_scale_ext       = '0;
      w_scale_ext[31:0] = r_scale;
      w_sd_ext          = '0;
      w_sd_ext[15:0]    = SD_AXIS_TDATA[15:0];
   end

   // Valid/ready: a VALID never depends on its own READY and, once high, holds with a stable
   // payload until the handshake; the STREAM state is a pure zero-latency passthrough.
   always_comb begin
      w_state_next = r_state;
      w_mac_valid  = 1'b0;
      w_mac_data   = '0;
      w_mac_last   = 1'b0;
      w_mac_user   = 1'b0;
      w_mac_tid    = '0;
      w_sd_ready   = 1'b0;
      w_res_ready  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (CMD_VALID) begin
               if (w_len_zero || w_prec_bad) w_state_next = ST_DONE;
               else                          w_state_next = ST_SEND_PREC;
            end
         end
         ST_SEND_PREC: begin
            w_mac_valid = 1'b1;
            w_mac_user  = 1'b1;
            w_mac_data  = w_prec_ext;
            w_mac_tid   = r_tid;
            if (M_MAC_TREADY) w_state_next = ST_SEND_SCALE;
         end
         ST_SEND_SCALE: begin
            w_mac_valid = 1'b1;
            w_mac_data  = w_scale_ext;
            w_mac_tid   = r_tid;
            if (M_MAC_TREADY) w_state_next = ST_STREAM;
         end
         ST_STREAM: begin
            w_mac_valid = SD_AXIS_TVALID;
            w_sd_ready  = M_MAC_TREADY;
            w_mac_data  = w_sd_ext;
            w_mac_last  = w_last;
            w_mac_tid   = r_tid;
            if (SD_AXIS_TVALID && M_MAC_TREADY && w_last) w_state_next = ST_WAIT_RES;
         end
         ST_WAIT_RES: begin
            w_res_ready = 1'b1;
            if (S_MAC_TVALID) w_state_next = ST_OUT_RES;
         end
         ST_OUT_RES: begin
            if (MO_AXIS_TREADY) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         r_state    <= ST_IDLE;
         r_prec     <= '0;
         r_scale    <= '0;
         r_len      <= '0;
         r_tid      <= '0;
         r_beat     <= '0;
         r_err      <= ERR_OK;
         r_res_data <= '0;
         r_res_tid  <= '0;
         r_job_cnt  <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            ST_IDLE: begin
               if (CMD_VALID) begin
                  r_prec  <= CMD_PRECISION;
                  r_scale <= CMD_SCALE;
                  r_len   <= CMD_LEN;
                  r_tid   <= CMD_TID;
                  r_beat  <= '0;
                  // Zero length takes priority over a bad precision code.
                  if (w_len_zero)      r_err <= ERR_ZERO_LEN;
                  else if (w_prec_bad) r_err <= ERR_BAD_PREC;
                  else                 r_err <= ERR_OK;
               end
            end
            ST_STREAM: begin
               if (w_mac_hs) r_beat <= r_beat + 16'd1;
            end
            ST_WAIT_RES: begin
               if (S_MAC_TVALID) begin
                  r_res_data <= S_MAC_TDATA;
                  r_res_tid  <= S_MAC_TID;
                  if (S_MAC_TID != r_tid) r_err <= ERR_TID;
               end
            end
            ST_DONE: begin
               r_job_cnt <= r_job_cnt + 16'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign CMD_READY      = (r_state == ST_IDLE);
   assign BUSY           = (r_state != ST_IDLE);
   assign JOB_DONE       = (r_state == ST_DONE);
   assign ERR_CODE       = r_err;
   assign JOB_CNT        = r_job_cnt;
   assign SD_AXIS_TREADY = w_sd_ready;
   assign M_MAC_TVALID   = w_mac_valid;
   assign M_MAC_TDATA    = w_mac_data;
   assign M_MAC_TLAST    = w_mac_last;
   assign M_MAC_TUSER    = w_mac_user;
   assign M_MAC_TID      = w_mac_tid;
   assign S_MAC_TREADY   = w_res_ready;
   assign MO_AXIS_TVALID = (r_state == ST_OUT_RES);
   assign MO_AXIS_TDATA  = r_res_data;
   assign MO_AXIS_TID    = r_res_tid;
   assign MO_AXIS_TLAST  = 1'b1;

`ifdef VP_SEQ_PERF_CNT_EN
   logic [31:0] r_cyc;
   logic [31:0] r_perf;
   logic [31:0] w_cyc_inc;

   // Saturating; the DONE cycle itself is counted, hence the copy of the incremented value.
   assign w_cyc_inc = (r_cyc == 32'hFFFF_FFFF) ? r_cyc : (r_cyc + 32'd1);

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         r_cyc  <= '0;
         r_perf <= '0;
      end else if (r_state == ST_IDLE) begin
         if (CMD_VALID) r_cyc <= '0;
      end else begin
         r_cyc <= w_cyc_inc;
         if (r_state == ST_DONE) r_perf <= w_cyc_inc;
      end
   end

   assign PERF_CYC = r_perf;
`endif

endmodule
